// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
// The decode stage imports this too, to steer M-extension ops away from the ALU.
package muldiv_pkg;

    localparam int XLEN = 32;
    localparam int MD_CNT_W = $clog2(XLEN);

    // funct3 encodings of the M-extension ops
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Divide/remainder ops all have funct3[2] set
    function automatic logic md_is_div(input logic [2:0] f);
        return f[2];
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic md_a_signed(input logic [2:0] f);
        return (f == MD_MULH) || (f == MD_MULHSU) || (f == MD_DIV) || (f == MD_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic md_b_signed(input logic [2:0] f);
        return (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide loop, purely combinational.
//   mode=0: shift-add multiply step. acc is the running high word, bit_in is
//           the current multiplier bit; qbit is the bit that drops out of acc
//           into the top of the low word.
//   mode=1: restoring divide step. acc is the partial remainder, bit_in is the
//           next dividend bit; qbit is the resulting quotient bit.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic            mode,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] opnd,
    input  logic            bit_in,
    output logic [XLEN-1:0] acc_nx,
    output logic            qbit
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;

    // Single add-and-shift or trial-subtract iteration
    always_comb begin
        acc_nx  = acc;
        qbit    = 1'b0;
        sum     = '0;
        shifted = '0;
        if (mode) begin
            shifted = {acc, bit_in};
            if (shifted >= {1'b0, opnd}) begin
                // the difference is below the divisor, so it fits in XLEN bits
                qbit   = 1'b1;
                acc_nx = shifted[XLEN-1:0] - opnd;
            end else begin
                acc_nx = shifted[XLEN-1:0];
            end
        end else begin
            sum    = {1'b0, acc} + (bit_in ? {1'b0, opnd} : '0);
            acc_nx = sum[XLEN:1];
            qbit   = sum[0];
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Works on operand magnitudes for 32 cycles, then applies the sign fix-up
// while loading the result register, so every output is a flop.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    import muldiv_pkg::*;

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state, state_nx;
    logic [CW-1:0]   cnt;
    logic [2:0]      op;
    logic            neg_res;

    // acc: product high word / partial remainder
    // lo : multiplier shifting out, product low word / dividend shifting out, quotient
    // opnd: multiplicand / divisor magnitude
    logic [XLEN-1:0] acc, lo, opnd;
    logic [XLEN-1:0] acc_nx, lo_nx;
    logic            qbit, bit_in, mode;

    logic            accept, special, last_iter;
    logic            a_neg, b_neg, neg_in;
    logic [XLEN-1:0] mag_a, mag_b, spec_val, final_val;

    function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] x);
        return ~x + XLEN'(1);
    endfunction

    // Sign fix-up and result selection once the loop has finished
    function automatic logic [XLEN-1:0] finalize(input logic [2:0]      f,
                                                 input logic            neg,
                                                 input logic [XLEN-1:0] hi,
                                                 input logic [XLEN-1:0] low);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   fixed_lo, fixed_hi;
        prod     = {hi, low};
        if (neg) prod = ~prod + (2*XLEN)'(1);
        fixed_lo = neg ? neg32(low) : low;
        fixed_hi = neg ? neg32(hi) : hi;
        case (f)
            MD_MUL:                      return prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: return prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:             return fixed_lo;
            default:                     return fixed_hi;
        endcase
    endfunction

    assign accept    = (state == MD_IDLE) && start && !flush;
    assign last_iter = (state == MD_CALC) && (cnt == CW'(XLEN-1));
    assign mode      = md_is_div(op);
    assign bit_in    = mode ? lo[XLEN-1] : lo[0];
    assign lo_nx     = mode ? {lo[XLEN-2:0], qbit} : {qbit, lo[XLEN-1:1]};
    assign final_val = finalize(op, neg_res, acc_nx, lo_nx);

    muldiv_step u_step (
        .mode   (mode),
        .acc    (acc),
        .opnd   (opnd),
        .bit_in (bit_in),
        .acc_nx (acc_nx),
        .qbit   (qbit)
    );

    // Operand magnitudes, result sign and divide special cases from the raw inputs
    always_comb begin
        a_neg    = md_a_signed(funct3) && A[XLEN-1];
        b_neg    = md_b_signed(funct3) && B[XLEN-1];
        mag_a    = a_neg ? neg32(A) : A;
        mag_b    = b_neg ? neg32(B) : B;
        // remainders follow the dividend; products and quotients the xor of signs
        neg_in   = (md_is_div(funct3) && funct3[1]) ? a_neg : (a_neg ^ b_neg);
        special  = 1'b0;
        spec_val = '0;
        if (md_is_div(funct3) && (B == '0)) begin
            special  = 1'b1;
            spec_val = funct3[1] ? A : ONES;
        end else if (((funct3 == MD_DIV) || (funct3 == MD_REM)) &&
                     (A == INT_MIN) && (B == ONES)) begin
            special  = 1'b1;
            spec_val = funct3[1] ? '0 : INT_MIN;
        end
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_nx = state;
        case (state)
            MD_IDLE: if (accept) state_nx = special ? MD_DONE : MD_CALC;
            MD_CALC: if (last_iter) state_nx = MD_DONE;
            MD_DONE: state_nx = MD_IDLE;
            default: state_nx = MD_IDLE;
        endcase
        if (flush) state_nx = MD_IDLE;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= MD_IDLE;
        else     state <= state_nx;
    end

    // Registered handshake outputs and iteration counter
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
        end else begin
            busy <= (state_nx != MD_IDLE);
            done <= (state_nx == MD_DONE);
            if (accept || flush)      cnt <= '0;
            else if (state == MD_CALC) cnt <= cnt + CW'(1);
        end
    end

    // Operand capture on accept, one loop iteration per CALC cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            op      <= funct3;
            neg_res <= neg_in;
            acc     <= '0;
            lo      <= md_is_div(funct3) ? mag_a : mag_b;
            opnd    <= md_is_div(funct3) ? mag_b : mag_a;
        end else if (state == MD_CALC) begin
            acc <= acc_nx;
            lo  <= lo_nx;
        end
    end

    // Result register: loaded by a special case or by the final iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
        end else if (accept && special) begin
            result <= spec_val;
        end else if (last_iter && !flush) begin
            result <= final_val;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq: directed corner cases plus randomized ops, with a
// result scoreboard fed by stimulus and drained by an independent monitor.
module tb_muldiv_seq;

    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] result;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] last_res;

    muldiv_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .A      (A),
        .B      (B),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, want %h (cycle %0d)", nm, got, want, cyc);
    endtask

    // Reference behaviour straight from the RV32M definitions
    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      p;
        logic [63:0] u;
        int          sa, sb2;
        sa  = a;
        sb2 = b;
        case (f)
            MD_MUL:    return a * b;
            MD_MULH:   begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
            MD_MULHSU: begin p = longint'($signed(a)) * longint'({32'h0, b}); return p[63:32]; end
            MD_MULHU:  begin u = {32'h0, a} * {32'h0, b}; return u[63:32]; end
            MD_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb2;
            end
            MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MD_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb2;
            end
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
        return (f[2] && b == 0) ||
               ((f == MD_DIV || f == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: got done=1, want no done (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("result", result, mon_e.val);
                chk("done_cycle", cyc, mon_e.cyc);
                chk("busy_at_done", 32'(busy), 32'd1);
            end
        end
    end

    // Drive one start pulse; returns at the falling edge of the cycle after it
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
        logic [31:0] r;
        @(negedge clk);
        start  = 1'b1;
        funct3 = f;
        A      = a;
        B      = b;
        if (push) begin
            r = ref_md(f, a, b);
            sb.push_back('{val: r, cyc: cyc + (is_special(f, a, b) ? 1 : 33)});
            last_res = r;
        end
        @(negedge clk);
        start  = 1'b0;
        funct3 = 3'($urandom);
        A      = $urandom;
        B      = $urandom;
    endtask

    task automatic wait_done();
        if (done) return;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) return;
        end
        n_chk++;
        $display("FAIL done_timeout: got no done in 40 cycles, want done (cycle %0d)", cyc);
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        issue(f, a, b, 1'b1);
        wait_done();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish by 1ms");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; A = '0; B = '0;
        last_res = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;

        // MUL with cycle-accurate busy window
        issue(MD_MUL, 32'd7, 32'd6, 1'b1);
        chk("mul_busy_c1", 32'(busy), 32'd1);
        for (int i = 2; i <= 34; i++) begin
            @(negedge clk);
            chk($sformatf("mul_busy_c%0d", i), 32'(busy), 32'(i <= 33));
        end

        run(MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(MD_DIV,    32'hFFFF_FFF9, 32'd2);
        run(MD_REM,    32'hFFFF_FFF9, 32'd2);
        run(MD_DIVU,   32'd100, 32'd7);
        run(MD_DIVU,   32'h1234, 32'h0);
        @(negedge clk);
        chk("special_busy_c2", 32'(busy), 32'd0);
        run(MD_REM,    32'h1234, 32'h0);
        run(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF);
        run(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF);

        // flush at cycle 10 of a DIV
        issue(MD_DIV, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_result", result, last_res);
        repeat (40) @(negedge clk);

        // start and flush together: nothing accepted
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = MD_MUL; A = 32'd3; B = 32'd5;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("startflush_busy", 32'(busy), 32'd0);
        repeat (38) @(negedge clk);
        chk("startflush_result", result, last_res);

        // start during CALC is ignored
        issue(MD_MUL, 32'd1000, 32'd3000, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1; funct3 = MD_DIVU; A = 32'd77; B = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // reset at cycle 5 of a REM, then a fresh op
        issue(MD_REM, 32'hDEAD_BEEF, 32'd12345, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", result, 32'd0);
        rst = 1'b0;
        last_res = '0;
        run(MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);

        // randomized ops, mostly back-to-back
        for (int n = 0; n < 150; n++) begin
            run(3'($urandom_range(0, 7)), pick(), pick());
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
